// File: rtl/down_scaler_2x2_if.sv
// Pixel stream bundle for the 2x2 down-scaler: raster input side, pooled output side and status.
interface down_scaler_2x2_if #(
  parameter int IN_W = 64,
  parameter int IN_H = 64,
  parameter int DW   = 8
);
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);

  logic          i_start;
  logic          i_pixel_valid;
  logic [DW-1:0] i_pixel;
  logic          pixel_out_valid;
  logic [DW-1:0] pixel_out;
  logic          o_busy;
  logic          o_done;
  logic [RW-1:0] o_in_row;
  logic [CW-1:0] o_in_col;

  modport master (
    output i_start, i_pixel_valid, i_pixel,
    input  pixel_out_valid, pixel_out, o_busy, o_done, o_in_row, o_in_col
  );

  modport slave (
    input  i_start, i_pixel_valid, i_pixel,
    output pixel_out_valid, pixel_out, o_busy, o_done, o_in_row, o_in_col
  );
endinterface

// File: rtl/down_scaler_2x2.sv
// 2x2 average-pool down-scaler: raster IN_W x IN_H frame in, (IN_W/2) x (IN_H/2) frame out,
// round-half-up. Even rows park horizontal pair sums in a half-width line buffer.
module down_scaler_2x2 #(
  parameter int IN_W = 64,
  parameter int IN_H = 64,
  parameter int DW   = 8
) (
  input logic              clk,
  input logic              reset,
  down_scaler_2x2_if.slave bus
);
  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [DW-1:0] pair_reg;
  logic [DW:0]   partial [IN_W/2];
  logic [DW-1:0] pix_q;
  logic          vld_q, done_q;

  logic          busy, accept, last_col, last_row;
  logic [CW-2:0] idx;
  logic [DW:0]   pair_sum;
  logic [DW+1:0] sum, rnd;

  assign busy     = (state == S_EVEN) || (state == S_ODD);
  assign accept   = bus.i_pixel_valid && busy;
  assign last_col = (in_col == CW'(IN_W - 1));
  assign last_row = (in_row == RW'(IN_H - 1));
  assign idx      = in_col[CW-1:1];
  assign pair_sum = {1'b0, pair_reg} + {1'b0, bus.i_pixel};
  assign sum      = {1'b0, partial[idx]} + {1'b0, pair_sum};
  assign rnd      = sum + (DW+2)'(2);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.i_start) state_nxt = S_EVEN;
      S_EVEN: if (accept && last_col) state_nxt = S_ODD;
      S_ODD:  if (accept && last_col) state_nxt = last_row ? S_DONE : S_EVEN;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_col   <= '0;
      in_row   <= '0;
      pair_reg <= '0;
      pix_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < IN_W/2; i++) partial[i] <= '0;
    end else begin
      vld_q  <= 1'b0;
      // Registered off S_DONE so the pulse lands the cycle after the final output pixel.
      done_q <= (state == S_DONE);
      if (state == S_IDLE && bus.i_start) begin
        in_col <= '0;
        in_row <= '0;
      end
      if (accept) begin
        if (last_col) begin
          in_col <= '0;
          in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
        if (!in_col[0])          pair_reg     <= bus.i_pixel;
        else if (state == S_EVEN) partial[idx] <= pair_sum;
        else begin
          pix_q <= rnd[DW+1:2];
          vld_q <= 1'b1;
        end
      end
    end

  assign bus.pixel_out_valid = vld_q;
  assign bus.pixel_out       = pix_q;
  assign bus.o_busy          = busy;
  assign bus.o_done          = done_q;
  assign bus.o_in_row        = in_row;
  assign bus.o_in_col        = in_col;
endmodule

// File: tb/tb_down_scaler_2x2.sv
// Directed + randomized frames against an arithmetic 2x2-average model of the frame.
module tb_down_scaler_2x2;
  localparam int IN_W = 64;
  localparam int IN_H = 64;
  localparam int DW   = 8;
  localparam int NOUT = (IN_W/2) * (IN_H/2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  down_scaler_2x2_if #(.IN_W(IN_W), .IN_H(IN_H), .DW(DW)) bus ();
  down_scaler_2x2 #(.IN_W(IN_W), .IN_H(IN_H), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int out_q[$];
  int out_cyc[$];
  int exp_cyc[$];
  int img [IN_H][IN_W];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.pixel_out_valid === 1'b1) begin
      out_q.push_back(int'(bus.pixel_out));
      out_cyc.push_back(cyc);
    end
    if (bus.o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int duty, input bit idle_junk, input bit mid_start,
                           input int abort_at);
    out_q.delete(); out_cyc.delete(); exp_cyc.delete();
    done_cnt = 0;
    @(negedge clk);
    if (idle_junk)
      repeat (5) begin
        bus.i_pixel_valid = 1'b1; bus.i_pixel = 8'($urandom);
        @(negedge clk);
      end
    bus.i_start = 1'b1; bus.i_pixel_valid = idle_junk; bus.i_pixel = 8'($urandom);
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_pixel_valid = 1'b0;
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++) begin
        while ($urandom_range(99) >= duty) begin
          bus.i_pixel_valid = 1'b0; bus.i_start = 1'b0;
          @(negedge clk);
        end
        bus.i_pixel_valid = 1'b1;
        bus.i_pixel = 8'(img[r][c]);
        bus.i_start = mid_start && (r*IN_W + c == 1000);
        if ((r % 2 == 1) && (c % 2 == 1)) exp_cyc.push_back(cyc + 1);
        if (r*IN_W + c == abort_at) begin
          bus.i_pixel_valid = 1'b0;
          reset = 1'b1;
          return;
        end
        @(negedge clk);
      end
    bus.i_pixel_valid = 1'b0; bus.i_start = 1'b0;
    for (int k = 0; k < 20 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int s, e, n, lat_bad;
    n = (out_q.size() < NOUT) ? out_q.size() : NOUT;
    check({tag, "_count"}, out_q.size(), NOUT);
    for (int i = 0; i < n; i++) begin
      s = img[2*(i/32)][2*(i%32)] + img[2*(i/32)][2*(i%32)+1]
        + img[2*(i/32)+1][2*(i%32)] + img[2*(i/32)+1][2*(i%32)+1];
      e = (s + 2) / 4;
      check($sformatf("%s_pix%0d", tag, i), out_q[i], e);
    end
    lat_bad = 0;
    for (int i = 0; i < n && i < exp_cyc.size(); i++)
      if (out_cyc[i] != exp_cyc[i]) lat_bad++;
    check({tag, "_latency"}, lat_bad, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    if (n > 0) check({tag, "_done_cyc"}, done_cyc, out_cyc[n-1] + 1);
  endtask

  initial begin
    int n;
    bus.i_start = 1'b0; bus.i_pixel_valid = 1'b0; bus.i_pixel = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.pixel_out_valid, 0);
    check("rst_pix",   bus.pixel_out, 0);
    check("rst_busy",  bus.o_busy, 0);
    check("rst_done",  bus.o_done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_row", bus.o_in_row, 0);
    check("idle_col", bus.o_in_col, 0);

    // flat 100
    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) img[r][c] = 100;
    run_frame(100, 1'b0, 1'b0, -1);
    check_frame("flat");
    check("flat_busy_after", bus.o_busy, 0);

    // rounding blocks in the first output positions, random elsewhere
    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) img[r][c] = $urandom_range(255);
    img[0][0] = 1;   img[0][1] = 2;   img[1][0] = 3;   img[1][1] = 4;
    img[0][2] = 0;   img[0][3] = 0;   img[1][2] = 0;   img[1][3] = 1;
    img[0][4] = 0;   img[0][5] = 0;   img[1][4] = 1;   img[1][5] = 1;
    img[0][6] = 255; img[0][7] = 255; img[1][6] = 255; img[1][7] = 255;
    run_frame(100, 1'b0, 1'b0, -1);
    check("round0", (out_q.size() > 0) ? out_q[0] : -1, 3);
    check("round1", (out_q.size() > 1) ? out_q[1] : -1, 0);
    check("round2", (out_q.size() > 2) ? out_q[2] : -1, 1);
    check("round3", (out_q.size() > 3) ? out_q[3] : -1, 255);
    check_frame("round");

    // ramp with ~50% valid duty
    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) img[r][c] = (r + c) & 255;
    run_frame(50, 1'b0, 1'b0, -1);
    check_frame("ramp");

    // idle pixels dropped, mid-frame start ignored
    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) img[r][c] = $urandom_range(255);
    run_frame(70, 1'b1, 1'b1, -1);
    check_frame("junk");

    // async reset mid-frame at input pixel 2000
    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) img[r][c] = $urandom_range(255);
    run_frame(100, 1'b0, 1'b0, 2000);
    #1;
    check("abort_valid", bus.pixel_out_valid, 0);
    check("abort_pix",   bus.pixel_out, 0);
    check("abort_row",   bus.o_in_row, 0);
    check("abort_col",   bus.o_in_col, 0);
    check("abort_busy",  bus.o_busy, 0);
    check("abort_done",  bus.o_done, 0);
    n = out_q.size();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_more_out", out_q.size(), n);
    check("abort_idle_busy", bus.o_busy, 0);

    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) img[r][c] = $urandom_range(255);
    run_frame(100, 1'b0, 1'b0, -1);
    check_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
